elevator_ctrl: RTL and testbench

- Car-motion controller for the elevator. It sits directly upstream of the Count timer block and drives that block's restart inputs `wait1n` (floor-travel timer) and `wait2n` (door-dwell timer).
- It consumes the timer's `wait1` / `wait2` expiry pulses.
- It latches floor call buttons, runs a direction-preserving (SCAN) service policy, and reports the current floor, direction, motion and door status.

---
 rtl/elevator_pkg.sv | 8 +
 rtl/req_pending.sv | 29 ++
 rtl/elevator_ctrl.sv | 86 ++++++++
 tb/tb_elevator_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: state encoding, default sizing and direction constants for the elevator controller
package elevator_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, MOVE_UP = 2'd1, MOVE_DOWN = 2'd2, DOOR = 2'd3} state_t;
  localparam int FLOORS_DEF = 4;
  localparam int FW_DEF = 2;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/req_pending.sv
// req_pending: latched call register with above/below/here reduction at the evaluation floor
module req_pending #(
  parameter int FLOORS = 4,
  parameter int FW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] req,
  input  logic [FLOORS-1:0] clr,
  input  logic [FW-1:0]     fsel,
  output logic [FLOORS-1:0] pending,
  output logic              above,
  output logic              below,
  output logic              here
);
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else pending <= (pending | req) & ~clr;
  end
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      above |= pending[i] && (i > int'(fsel));
      below |= pending[i] && (i < int'(fsel));
    end
    here = pending[fsel];
  end
endmodule

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: SCAN car-motion controller driving the travel/dwell timer restarts
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int FLOORS = FLOORS_DEF,
  parameter int FW = FW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] req,
  input  logic              wait1,
  input  logic              wait2,
  output logic              wait1n,
  output logic              wait2n,
  output logic [FW-1:0]     floor,
  output logic              dir_up,
  output logic              moving,
  output logic              door_open,
  output logic [FLOORS-1:0] pending
);
  state_t state, nxt;
  logic arrive, at_end, w1, w2, ndir, above, below, here;
  logic [FW-1:0] fe;
  logic [FLOORS-1:0] clr;
  assign arrive = (state == MOVE_UP || state == MOVE_DOWN) && wait1 && !wait1n;
  assign at_end = (state == MOVE_UP && floor == FW'(FLOORS - 1)) || (state == MOVE_DOWN && floor == '0);
  assign fe = (!arrive || at_end) ? floor : (state == MOVE_UP) ? floor + FW'(1) : floor - FW'(1);
  assign clr = (w2 || state == DOOR) ? FLOORS'(1) << fe : '0;
  req_pending #(.FLOORS(FLOORS), .FW(FW)) u_req (
    .clk(clk),
    .reset(reset),
    .req(req),
    .clr(clr),
    .fsel(fe),
    .pending(pending),
    .above(above),
    .below(below),
    .here(here)
  );
  always_comb begin
    nxt = state;
    ndir = dir_up;
    w1 = 1'b0;
    w2 = 1'b0;
    if (state == IDLE) begin
      if (here) begin
        nxt = DOOR;
        w2 = 1'b1;
      end else if (above && (dir_up || !below)) begin
        nxt = MOVE_UP;
        ndir = DIR_UP;
        w1 = 1'b1;
      end else if (below) begin
        nxt = MOVE_DOWN;
        ndir = DIR_DOWN;
        w1 = 1'b1;
      end
    end else if (arrive) begin
      if (at_end) nxt = IDLE;
      else if (here) begin
        nxt = DOOR;
        w2 = 1'b1;
      end else if (state == MOVE_UP ? above : below) w1 = 1'b1;
      else nxt = IDLE;
    end else if (state == DOOR && wait2 && !wait2n) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      floor <= '0;
      dir_up <= DIR_UP;
      wait1n <= 1'b0;
      wait2n <= 1'b0;
      moving <= 1'b0;
      door_open <= 1'b0;
    end else begin
      state <= nxt;
      floor <= fe;
      dir_up <= ndir;
      wait1n <= w1;
      wait2n <= w2;
      moving <= nxt == MOVE_UP || nxt == MOVE_DOWN;
      door_open <= nxt == DOOR;
    end
  end
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: scoreboard bench with a timer model answering wait1n/wait2n pulses
module tb_elevator_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = '0;
  logic wait1, wait2;
  logic wait1n, wait2n, dir_up, moving, door_open;
  logic [1:0] floor;
  logic [3:0] pending;
  logic t1 = 1'b0, t2 = 1'b0, m1 = 1'b0, m2 = 1'b0, auto_t = 1'b1, prev = 1'b0;
  int c1 = 0, c2 = 0;
  int errors = 0, checks = 0;
  int q[$];
  assign wait1 = t1 | m1;
  assign wait2 = t2 | m2;
  always #5 clk = ~clk;
  elevator_ctrl dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .wait1(wait1),
    .wait2(wait2),
    .wait1n(wait1n),
    .wait2n(wait2n),
    .floor(floor),
    .dir_up(dir_up),
    .moving(moving),
    .door_open(door_open),
    .pending(pending)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int ev(input int kind, input int f, input int d);
    return kind * 100 + f * 10 + d;
  endfunction
  initial forever begin
    @(negedge clk);
    t1 = 1'b0;
    t2 = 1'b0;
    if (c1 > 0) begin
      c1--;
      if (c1 == 0) t1 = auto_t;
    end
    if (c2 > 0) begin
      c2--;
      if (c2 == 0) t2 = auto_t;
    end
    if (wait1n) c1 = 3;
    if (wait2n) c2 = 2;
  end
  initial forever begin
    int code, exp;
    @(negedge clk);
    if (wait1n || wait2n) begin
      check("pulse_adjacent", int'(prev), 0);
      code = ev(int'({wait2n, wait1n}), int'(floor), int'(dir_up));
      exp = (q.size() > 0) ? q.pop_front() : -1;
      check("pulse_event", code, exp);
    end
    prev = wait1n || wait2n;
  end
  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic pulse_req(input logic [3:0] v);
    req = v;
    @(negedge clk);
    req = '0;
  endtask
  task automatic wait_door(input int max);
    for (int i = 0; i < max && !door_open; i++) @(negedge clk);
    check("timeout_door", int'(door_open), 1);
  endtask
  task automatic wait_floor(input int f, input int max);
    for (int i = 0; i < max && int'(floor) != f; i++) @(negedge clk);
    check("timeout_floor", int'(floor), f);
  endtask
  task automatic wait_idle(input int max);
    for (int i = 0; i < max && (moving || door_open || pending != 0); i++) @(negedge clk);
    check("timeout_idle", int'(moving || door_open || pending != 0), 0);
  endtask
  initial begin
    do_reset();
    check("rst_floor", int'(floor), 0);
    check("rst_dir", int'(dir_up), 1);
    check("rst_pending", int'(pending), 0);
    check("rst_moving", int'(moving), 0);
    check("rst_door", int'(door_open), 0);
    check("rst_w1n", int'(wait1n), 0);
    check("rst_w2n", int'(wait2n), 0);
    repeat (10) @(negedge clk);
    check("idle_floor", int'(floor), 0);
    check("idle_pending", int'(pending), 0);
    check("idle_moving", int'(moving), 0);
    q.push_back(ev(1, 0, 1));
    q.push_back(ev(1, 1, 1));
    q.push_back(ev(1, 2, 1));
    q.push_back(ev(2, 3, 1));
    pulse_req(4'b1000);
    wait_door(100);
    check("t2_floor", int'(floor), 3);
    check("t2_pending", int'(pending), 0);
    wait_idle(100);
    check("t2_closed", int'(door_open), 0);
    do_reset();
    q.push_back(ev(1, 0, 1));
    q.push_back(ev(2, 1, 1));
    q.push_back(ev(1, 1, 1));
    q.push_back(ev(2, 2, 1));
    pulse_req(4'b0100);
    @(negedge clk);
    pulse_req(4'b0010);
    check("t3_pending", int'(pending), 6);
    wait_door(100);
    check("t3_stop1", int'(floor), 1);
    wait_idle(200);
    check("t3_floor", int'(floor), 2);
    check("t3_dir", int'(dir_up), 1);
    do_reset();
    q.push_back(ev(1, 0, 1));
    q.push_back(ev(1, 1, 1));
    q.push_back(ev(2, 2, 1));
    q.push_back(ev(1, 2, 0));
    q.push_back(ev(1, 1, 0));
    q.push_back(ev(2, 0, 0));
    pulse_req(4'b0100);
    wait_door(100);
    req = 4'b0101;
    @(negedge clk);
    req = '0;
    check("t4_pending", int'(pending), 1);
    check("t4_door", int'(door_open), 1);
    wait_idle(200);
    check("t4_floor", int'(floor), 0);
    check("t4_dir", int'(dir_up), 0);
    do_reset();
    q.push_back(ev(1, 0, 1));
    q.push_back(ev(1, 1, 1));
    pulse_req(4'b1000);
    wait_floor(1, 100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_floor", int'(floor), 0);
    check("t5_pending", int'(pending), 0);
    check("t5_moving", int'(moving), 0);
    repeat (6) @(negedge clk);
    check("t5_late_floor", int'(floor), 0);
    check("t5_late_moving", int'(moving), 0);
    do_reset();
    q.push_back(ev(1, 0, 1));
    q.push_back(ev(2, 1, 1));
    pulse_req(4'b0010);
    wait_idle(100);
    auto_t = 1'b0;
    q.push_back(ev(1, 1, 0));
    q.push_back(ev(2, 0, 0));
    pulse_req(4'b0001);
    repeat (2) @(negedge clk);
    check("t6_moving", int'(moving), 1);
    m1 = 1'b1;
    m2 = 1'b1;
    @(negedge clk);
    m1 = 1'b0;
    m2 = 1'b0;
    check("t6_floor", int'(floor), 0);
    check("t6_door", int'(door_open), 1);
    repeat (3) @(negedge clk);
    check("t6_dwell", int'(door_open), 1);
    m2 = 1'b1;
    @(negedge clk);
    m2 = 1'b0;
    check("t6_closed", int'(door_open), 0);
    check("t6_pending", int'(pending), 0);
    auto_t = 1'b1;
    repeat (3) @(negedge clk);
    check("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
